dm_access_unit: RTL and testbench

- Memory-access (MA) stage controller for the SimpleRISC pipeline.
- Issues loads and stores to a variable-latency data memory over a req/ack handshake.
- Produces `dm_done`, which the stall logic uses to hold the pipeline while a load is outstanding.
- Stores are posted into a small in-order store buffer with youngest-match forwarding to loads, so stores never wait for memory unless the buffer is full.

---
 rtl/simplerisc_dm_pkg.sv | 25 ++
 rtl/store_buffer.sv | 77 +++++++
 rtl/dm_access_unit.sv | 143 ++++++++++++++
 tb/tb_dm_access_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_dm_pkg.sv
// simplerisc_dm_pkg
// Shared types for the SimpleRISC memory-access stage:
//   - dm_state_t : access-controller FSM states
//   - sb_entry_t : one posted store {addr, data}
//   - DM_DATA_W / DM_ADDR_W : default data and word-address widths
package simplerisc_dm_pkg;

    localparam int DM_DATA_W = 32;
    localparam int DM_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_REQ = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } dm_state_t;

    // The entry carries the package widths, so the unit's DATA_W/ADDR_W
    // parameters are expected to stay at these defaults.
    typedef struct packed {
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// store_buffer
// In-order circular FIFO of posted stores with a youngest-match lookup
// used for store-to-load forwarding.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   push, push_entry  : append an entry at the tail (caller ensures !full)
//   pop               : drop the head entry (caller ensures !empty)
//   full, empty       : occupancy flags derived from the registered count
//   head              : oldest entry, the next one to be written to memory
//   lookup_addr       : load address to search for
//   hit, hit_data     : some valid entry matches; data of the youngest match
module store_buffer
    import simplerisc_dm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  sb_entry_t            push_entry,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output sb_entry_t            head,
    input  logic [DM_ADDR_W-1:0] lookup_addr,
    output logic                 hit,
    output logic [DM_DATA_W-1:0] hit_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = entries[head_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data-path only; stale slots are masked by count.
    always_ff @(posedge clk) begin
        if (push) entries[tail_ptr] <= push_entry;
    end

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (entries[head_ptr + PTR_W'(i)].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[head_ptr + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit
// Memory-access stage controller: issues loads and drains posted stores to a
// variable-latency data memory, forwarding buffered store data to loads.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   is_Ld, is_St          : MA-stage instruction is a load / store
//   ext_hold              : pipeline frozen for a non-memory reason
//   alu_result, st_data   : effective address, store data
//   dm_done, ld_result    : load complete (MA may advance), loaded word
//   st_stall              : store blocked, store buffer full
//   sb_empty              : store buffer empty
//   mem_req/we/addr/wdata : registered memory request
//   mem_rdata, mem_ack    : memory read data and one-cycle completion pulse
//
// Memory handshake: mem_req rises with we/addr/wdata, and all four hold
// steady until the cycle in which mem_ack is high; mem_req is low the cycle
// after that ack, so at most one request is ever in flight. An ack seen
// while no request is pending (e.g. left over from a reset) is ignored.
module dm_access_unit
    import simplerisc_dm_pkg::*;
#(
    parameter int DATA_W   = DM_DATA_W,
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_Ld,
    input  logic              is_St,
    input  logic              ext_hold,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] st_data,
    output logic              dm_done,
    output logic [DATA_W-1:0] ld_result,
    output logic              st_stall,
    output logic              sb_empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    dm_state_t         state;
    logic              sb_full;
    logic              sb_is_empty;
    logic              sb_push;
    logic              sb_pop;
    sb_entry_t         sb_head;
    sb_entry_t         sb_new;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // A simultaneous load+store is treated as a load, so the store side is
    // masked by is_Ld. Full is registered: no push-through on the pop cycle.
    assign sb_push  = is_St & ~is_Ld & ~sb_full & ~ext_hold;
    assign sb_pop   = (state == DRAIN) & mem_ack;
    assign st_stall = is_St & ~is_Ld & sb_full;
    assign sb_empty = sb_is_empty;
    assign sb_new   = '{addr: alu_result, data: st_data};

    store_buffer #(
        .DEPTH (SB_DEPTH)
    ) u_store_buffer (
        .clk         (clk),
        .reset       (reset),
        .push        (sb_push),
        .push_entry  (sb_new),
        .pop         (sb_pop),
        .full        (sb_full),
        .empty       (sb_is_empty),
        .head        (sb_head),
        .lookup_addr (alu_result),
        .hit         (fwd_hit),
        .hit_data    (fwd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_result <= '0;
            dm_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Loads take priority over draining; a hit never touches
                    // memory, which is what keeps loads from reading stale data.
                    if (is_Ld) begin
                        if (fwd_hit) begin
                            ld_result <= fwd_data;
                            dm_done   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= alu_result;
                            state    <= LD_REQ;
                        end
                    end else if (!sb_is_empty) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= sb_head.addr;
                        mem_wdata <= sb_head.data;
                        state     <= DRAIN;
                    end
                end
                LD_REQ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        ld_result <= mem_rdata;
                        dm_done   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DRAIN: begin
                    // The entry stays visible to forwarding until this ack pops it.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    // Waiting here on ext_hold keeps the same load from re-issuing.
                    if (!ext_hold) begin
                        dm_done <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    dm_done <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;
  localparam int DW = 32;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic is_Ld, is_St, ext_hold;
  logic [AW-1:0] alu_result;
  logic [DW-1:0] st_data;
  logic dm_done, st_stall, sb_empty, mem_req, mem_we, mem_ack;
  logic [DW-1:0] ld_result, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  dm_access_unit #(.DATA_W(DW), .ADDR_W(AW), .SB_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .is_Ld(is_Ld), .is_St(is_St), .ext_hold(ext_hold),
    .alu_result(alu_result), .st_data(st_data), .dm_done(dm_done),
    .ld_result(ld_result), .st_stall(st_stall), .sb_empty(sb_empty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) assert (!(is_Ld && is_St)) else $error("illegal is_Ld and is_St together");

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW+DW-1:0] wr_exp_q[$];
  logic [DW-1:0] ld_exp_q[$];
  int lat = 1;
  bit hold_ack = 1'b0;
  bit force_ack = 1'b0;
  int rd_count = 0;
  int wr_ack_cyc = 0;
  int rd_start_cyc = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  // Architectural view: the youngest store not yet written wins, else memory.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    for (int i = wr_exp_q.size() - 1; i >= 0; i--)
      if (wr_exp_q[i][AW+DW-1:DW] == a) return wr_exp_q[i][DW-1:0];
    return mem_read(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int req_cnt;
    req_cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (force_ack) begin
        mem_ack = 1'b1;
        force_ack = 1'b0;
      end else if (mem_req) begin
        req_cnt++;
        if (req_cnt >= lat && !hold_ack) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem_read(mem_addr);
          req_cnt = 0;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic p_req, p_ack_req, p_done, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_ld;
    logic [AW+DW-1:0] w;
    p_req = 0; p_ack_req = 0; p_done = 0; p_we = 0; p_addr = '0; p_wdata = '0; p_ld = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (p_ack_req) chk("req_drop", 64'(mem_req), 0);
        else if (p_req && mem_req) begin
          chk("req_stable_addr", 64'(mem_addr), 64'(p_addr));
          chk("req_stable_wdata", 64'({mem_we, mem_wdata}), 64'({p_we, p_wdata}));
        end
        if (mem_req && mem_ack) begin
          if (mem_we) begin
            wr_ack_cyc = cyc;
            chk("wr_expected", 64'(wr_exp_q.size() != 0), 1);
            if (wr_exp_q.size() != 0) begin
              w = wr_exp_q.pop_front();
              chk("wr_order", 64'({mem_addr, mem_wdata}), 64'(w));
            end
          end else begin
            rd_count++;
          end
        end
        if (mem_req && !mem_we && !p_req) rd_start_cyc = cyc;
        if (dm_done && !p_done) begin
          chk("ld_expected", 64'(ld_exp_q.size() != 0), 1);
          if (ld_exp_q.size() != 0) chk("ld_result", 64'(ld_result), 64'(ld_exp_q.pop_front()));
        end else if (dm_done && p_done) begin
          chk("ld_stable", 64'(ld_result), 64'(p_ld));
        end
        p_req = mem_req; p_ack_req = mem_req & mem_ack; p_done = dm_done;
        p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_ld = ld_result;
      end else begin
        p_req = 0; p_ack_req = 0; p_done = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      is_Ld = 0; is_St = 0; ext_hold = 0;
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input int hold);
    int n;
    @(negedge clk);
    is_St = 0; is_Ld = 1; ext_hold = 0; alu_result = a; st_data = $urandom;
    ld_exp_q.push_back(model_read(a));
    #1;
    n = 0;
    while (!dm_done && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("ld_complete", 64'(dm_done), 1);
    for (int h = 0; h < hold; h++) begin
      ext_hold = 1;
      @(negedge clk); #1;
      chk("hold_done", 64'(dm_done), 1);
    end
    ext_hold = 0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input int pre_hold);
    int n;
    @(negedge clk);
    is_Ld = 0; is_St = 1; alu_result = a; st_data = d; ext_hold = 0;
    if (pre_hold > 0) begin
      ext_hold = 1;
      repeat (pre_hold) @(negedge clk);
      ext_hold = 0;
    end
    #1;
    n = 0;
    while (st_stall && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("st_accept", 64'(st_stall), 0);
    wr_exp_q.push_back({a, d});
  endtask

  task automatic wait_quiet();
    int n;
    idle(1);
    #1;
    n = 0;
    while (!(sb_empty && !mem_req && !dm_done) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("quiet_sb_empty", 64'(sb_empty), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, rd0;
    reset = 1; is_Ld = 0; is_St = 0; ext_hold = 0; alu_result = '0; st_data = '0;
    mem[32'h40] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_ld_result", 64'(ld_result), 0);
    chk("rst_dm_done", 64'(dm_done), 0);
    chk("rst_st_stall", 64'(st_stall), 0);
    chk("rst_sb_empty", 64'(sb_empty), 1);

    // Load miss, ack on third request cycle
    lat = 3;
    @(negedge clk);
    is_Ld = 1; alu_result = 32'h40;
    ld_exp_q.push_back(model_read(32'h40));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      chk("miss_req", 64'(mem_req), 64'(c <= 3));
      chk("miss_done", 64'(dm_done), 64'(c == 4));
    end
    wait_quiet();

    // Hold in DONE: one read only, result stable
    lat = 2;
    rd0 = rd_count;
    do_load(32'h44, 2);
    idle(3);
    chk("hold_one_read", 64'(rd_count), 64'(rd0 + 1));
    wait_quiet();

    // Forwarding: youngest of two matching entries, no memory read
    hold_ack = 1; lat = 1;
    do_store(32'h20, 32'hAAAA5555, 0);
    do_store(32'h10, 32'h11111111, 0);
    do_store(32'h10, 32'h22222222, 0);
    rd0 = rd_count;
    @(negedge clk);
    is_St = 0; is_Ld = 1; alu_result = 32'h10;
    ld_exp_q.push_back(model_read(32'h10));
    repeat (3) begin @(negedge clk); #1; end
    chk("fwd_wait_drain", 64'(dm_done), 0);
    hold_ack = 0;
    n = 0;
    while (!mem_ack && n < 50) begin @(negedge clk); #1; n++; end
    chk("fwd_drain_ack", 64'(mem_ack), 1);
    @(negedge clk); #1;
    chk("fwd_idle", 64'(dm_done), 0);
    @(negedge clk); #1;
    chk("fwd_done", 64'(dm_done), 1);
    chk("fwd_no_req", 64'(mem_req), 0);
    wait_quiet();
    chk("fwd_no_read", 64'(rd_count), 64'(rd0));

    // Buffer full
    hold_ack = 1; lat = 1;
    for (int i = 0; i < 4; i++) do_store(AW'(i), 32'h5555_0000 + DW'(i), 0);
    @(negedge clk);
    is_Ld = 0; is_St = 1; alu_result = 32'h4; st_data = 32'h5555_0004;
    #1;
    chk("full_stall", 64'(st_stall), 1);
    repeat (2) begin @(negedge clk); #1; chk("full_stall_hold", 64'(st_stall), 1); end
    hold_ack = 0;
    n = 0;
    while (!mem_ack && n < 50) begin @(negedge clk); #1; n++; end
    chk("full_ack_seen", 64'(mem_ack), 1);
    chk("full_stall_ack", 64'(st_stall), 1);
    @(negedge clk); #1;
    chk("full_release", 64'(st_stall), 0);
    wr_exp_q.push_back({32'h4, 32'h5555_0004});
    wait_quiet();

    // Load during drain
    lat = 4;
    do_store(32'h90, $urandom, 0);
    idle(1);
    do_load(32'h80, 0);
    wait_quiet();
    chk("drain_then_read", 64'(rd_start_cyc - wr_ack_cyc), 2);

    // Reset with a request outstanding, then a stray ack
    hold_ack = 1; lat = 1;
    do_store(32'h30, 32'h12345678, 0);
    idle(2);
    #1;
    chk("rst_pre_req", 64'(mem_req), 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    wr_exp_q.delete();
    ld_exp_q.delete();
    hold_ack = 0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 0);
    chk("rst_mid_done", 64'(dm_done), 0);
    chk("rst_mid_empty", 64'(sb_empty), 1);
    force_ack = 1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("stray_req", 64'(mem_req), 0);
    chk("stray_done", 64'(dm_done), 0);
    chk("stray_empty", 64'(sb_empty), 1);
    do_load(32'h30, 0);
    wait_quiet();

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1)
        do_load(32'h100 + $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      else
        do_store(32'h100 + $urandom_range(0, 5), $urandom, ($urandom_range(0, 4) == 0) ? 1 : 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    wait_quiet();
    idle(2);
    chk("final_wr_q_empty", 64'(wr_exp_q.size()), 0);
    chk("final_ld_q_empty", 64'(ld_exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
